// File: rtl/crc8_frame_arbiter.sv
// crc8_frame_arbiter: shares one bit-serial CRC-8 engine between two byte streams,
// with frame-granular round-robin and a valid/ready result port tagged with the owner.
module crc8_frame_arbiter #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, NEXT, RESULT} state_t;
  state_t state, state_n;
  logic       rr, gnt, last_r, busy_r, acc, hs, fb;
  logic [7:0] lfsr, byte_r;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      rr     <= 1'b0;
      gnt    <= 1'b0;
      lfsr   <= INIT;
      cnt    <= 3'd0;
      byte_r <= 8'h00;
      last_r <= 1'b0;
    end else begin
      state  <= state_n;
      busy_r <= state_n != IDLE;
      if (clr) lfsr <= INIT;
      else begin
        if (acc) begin
          byte_r <= req1_ready ? req1_data : req0_data;
          last_r <= req1_ready ? req1_last : req0_last;
          cnt    <= 3'd7;
          if (state == IDLE) begin
            gnt  <= req1_ready;
            lfsr <= INIT;
          end
        end
        if (state == SHIFT) begin
          lfsr <= {lfsr[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
          cnt  <= cnt - 3'd1;
        end
        if (hs) rr <= ~gnt;
      end
    end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, NEXT: if (acc) state_n = SHIFT;
      SHIFT:      if (cnt == 3'd0) state_n = last_r ? RESULT : NEXT;
      RESULT:     if (hs) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
    if (clr) state_n = IDLE;
  end

  // clr gates the readies so a byte offered during an abort is never consumed
  always_comb begin
    req0_ready = !clr && req0_valid &&
                 ((state == IDLE && (!req1_valid || !rr)) || (state == NEXT && !gnt));
    req1_ready = !clr && req1_valid &&
                 ((state == IDLE && (!req0_valid || rr)) || (state == NEXT && gnt));
    acc        = req0_ready || req1_ready;
    res_valid  = state == RESULT;
    res_data   = res_valid ? lfsr : 8'h00;
    res_id     = res_valid && gnt;
    hs         = res_valid && res_ready && !clr;
    fb         = lfsr[7] ^ byte_r[cnt];
    busy       = busy_r;
  end
endmodule
